sdram_rd_checker: RTL

- Synthesizable read-side consumer for the SDRAM controller's read FIFO interface; sits directly downstream of the read FIFO (dout / ren).
- Drains words, locks onto the first word received, then checks that the stream increments by 1 per word (mod 2^DATA_W). This matches the counting pattern the write side produces.
- Reports pass/fail, error count and first-mismatch details for on-board bring-up and regression.

---
 rtl/sdram_tb_pkg.sv | 29 ++
 rtl/sdram_rd_checker_if.sv | 30 +++
 rtl/sdram_rd_checker_rd_valid_pipe.sv | 36 +++
 rtl/sdram_rd_checker.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sdram_tb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_tb_pkg
// Shared definitions for the SDRAM bring-up traffic blocks. The read-side
// checker and the write-side pattern generator both use these, so the two
// ends always agree on the data pattern.
//   state_e        : checker state encoding (IDLE/SYNC/CHECK/DONE)
//   DEF_DATA_W     : default FIFO data width
//   DEF_CNT_W      : default word/error counter width
//   next_pattern() : successor of a pattern word (x + 1). It works on 64 bits,
//                    so the caller truncates the result to its own width,
//                    which gives the modulo-2^DATA_W wrap.
// -----------------------------------------------------------------------------
package sdram_tb_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [63:0] next_pattern(input logic [63:0] x);
        return x + 64'd1;
    endfunction

endpackage

// File: rtl/sdram_rd_checker_if.sv
// -----------------------------------------------------------------------------
// sdram_rd_checker_if
// Read-FIFO pop interface between the SDRAM controller's read FIFO and a
// consumer.
//   ren       : read enable, driven by the consumer
//   rd_empty  : FIFO empty flag
//   fifo_dout : FIFO data, valid a fixed latency after an accepted ren
// Modports:
//   master : the consumer that pops the FIFO (the checker)
//   slave  : the FIFO side
// -----------------------------------------------------------------------------
interface sdram_rd_checker_if #(
    parameter int DATA_W = 16
);
    logic              ren;
    logic              rd_empty;
    logic [DATA_W-1:0] fifo_dout;

    modport master (
        output ren,
        input  rd_empty,
        input  fifo_dout
    );

    modport slave (
        input  ren,
        output rd_empty,
        output fifo_dout
    );
endinterface

// File: rtl/sdram_rd_checker_rd_valid_pipe.sv
// -----------------------------------------------------------------------------
// rd_valid_pipe
// Delays the read enable by the FIFO read latency. rvalid marks the cycle in
// which fifo_dout carries the word requested RD_LAT cycles earlier.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   ren    : read enable that the FIFO accepted
//   rvalid : ren delayed by RD_LAT cycles
// -----------------------------------------------------------------------------
module rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ren,
    output logic rvalid
);

    logic [RD_LAT-1:0] sr;

    // NOTE: the valid pipe is reset. Any read still in flight at reset is
    // dropped, so stale FIFO data can never be counted in the next run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign rvalid = sr[RD_LAT-1];

endmodule

// File: rtl/sdram_rd_checker.sv
// -----------------------------------------------------------------------------
// sdram_rd_checker
// Read-side consumer for the SDRAM read FIFO. It drains CHECK_LEN words and
// locks onto the first word. It then checks that every later word is the
// previous word + 1 (mod 2^DATA_W). Results are held for on-board readout.
//   r_clk         : read-side clock (the only clock)
//   rst_n         : asynchronous active-low reset
//   start         : one-cycle run request, honoured in IDLE or DONE only
//   fifo          : read-FIFO pop interface (ren / rd_empty / fifo_dout)
//   busy          : run in progress (SYNC or CHECK)
//   done          : run finished, results valid
//   pass          : no mismatches in the last run (valid with done)
//   word_cnt      : words consumed in this run
//   err_cnt       : mismatches in this run, saturating
//   first_err_idx : word_cnt value of the first mismatching word
//   first_err_exp : expected value at the first mismatch
//   first_err_got : received value at the first mismatch
// -----------------------------------------------------------------------------
module sdram_rd_checker
    import sdram_tb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CHECK_LEN = 1024,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              r_clk,
    input  logic              rst_n,
    input  logic              start,
    sdram_rd_checker_if.master fifo,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] SYNC  = ST_SYNC;
    localparam logic [1:0] CHECK = ST_CHECK;
    localparam logic [1:0] DONE  = ST_DONE;

    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHECK_LEN);

    logic [1:0]        state;
    logic [CNT_W-1:0]  issue_cnt;
    logic [DATA_W-1:0] exp_word;
    logic              err_seen;
    logic              ren;
    logic              rvalid;

    logic              mismatch;
    logic [CNT_W-1:0]  wc_nxt;
    logic [CNT_W-1:0]  err_inc;
    logic [CNT_W-1:0]  err_nxt;

    assign busy = (state == SYNC) || (state == CHECK);
    assign done = (state == DONE);

    // Reads stop once CHECK_LEN words have been requested. Words that are
    // already in flight still arrive and are checked.
    assign ren      = busy && !fifo.rd_empty && (issue_cnt < LEN);
    assign fifo.ren = ren;

    assign mismatch = (fifo.fifo_dout != exp_word);
    assign wc_nxt   = word_cnt + CNT_W'(1);
    assign err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
    assign err_nxt  = mismatch ? err_inc : err_cnt;

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_valid_pipe (
        .clk    (r_clk),
        .rst_n  (rst_n),
        .ren    (ren),
        .rvalid (rvalid)
    );

    // NOTE: all state here is sequential and uses non-blocking assignments,
    // so every read of a register in this block sees its pre-edge value.
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            issue_cnt     <= '0;
            exp_word      <= '0;
            err_seen      <= 1'b0;
            pass          <= 1'b0;
            word_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            if (ren) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= SYNC;
                        issue_cnt     <= '0;
                        err_seen      <= 1'b0;
                        pass          <= 1'b0;
                        word_cnt      <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '0;
                        first_err_exp <= '0;
                        first_err_got <= '0;
                    end
                end

                SYNC: begin
                    // The first word defines the sequence and cannot mismatch.
                    if (rvalid) begin
                        exp_word <= DATA_W'(next_pattern(64'(fifo.fifo_dout)));
                        word_cnt <= CNT_W'(1);
                        if (CHECK_LEN == 1) begin
                            state <= DONE;
                            pass  <= 1'b1;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    // The expected value advances regardless of the outcome.
                    // A dropped word therefore shows up as a run of
                    // mismatches rather than being hidden by a resync.
                    if (rvalid) begin
                        exp_word <= DATA_W'(next_pattern(64'(exp_word)));
                        word_cnt <= wc_nxt;
                        err_cnt  <= err_nxt;
                        if (mismatch && !err_seen) begin
                            err_seen      <= 1'b1;
                            first_err_idx <= wc_nxt;
                            first_err_exp <= exp_word;
                            first_err_got <= fifo.fifo_dout;
                        end
                        if (wc_nxt == LEN) begin
                            state <= DONE;
                            pass  <= (err_nxt == '0);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
